// File: rtl/pe_op_scheduler.sv
// Job sequencer for one PE: configures op mode, clears the accumulator, issues feed strobes, drains, reports done.
// Optional feature macro PE_SCHED_STALL_EN adds stall_i, which holds off feeds while in RUN.
module pe_op_scheduler #(
  parameter int unsigned LEN_BW    = 8,
  parameter int unsigned ITER_BW   = 4,
  parameter int unsigned DRAIN_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
`ifdef PE_SCHED_STALL_EN
  input  logic               stall_i,
`endif
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [1:0]         req_mode_i,
  input  logic [LEN_BW-1:0]  req_len_i,
  input  logic [ITER_BW-1:0] req_iter_i,
  output logic [1:0]         gemm_uno_o,
  output logic               acc_clr_o,
  output logic               x_valid_o,
  output logic [ITER_BW-1:0] term_idx_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int unsigned DRAIN_BW = 4;

  typedef enum logic [2:0] {IDLE, CFG, RUN, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [LEN_BW-1:0]  len_q, len_d, samp_q, samp_d;
  logic [ITER_BW-1:0] iter_q, iter_d, term_q, term_d;
  logic [DRAIN_BW-1:0] drain_q, drain_d;
  logic [1:0]         mode_q, mode_d;
  logic               ready_q, ready_d, clr_q, clr_d, xv_q, xv_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               stall;

`ifdef PE_SCHED_STALL_EN
  assign stall = stall_i;
`else
  assign stall = 1'b0;
`endif

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      samp_q  <= '0;
      iter_q  <= '0;
      term_q  <= '0;
      drain_q <= '0;
      mode_q  <= 2'b00;
      ready_q <= 1'b1;
      clr_q   <= 1'b0;
      xv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      samp_q  <= samp_d;
      iter_q  <= iter_d;
      term_q  <= term_d;
      drain_q <= drain_d;
      mode_q  <= mode_d;
      ready_q <= ready_d;
      clr_q   <= clr_d;
      xv_q    <= xv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state and next-cycle output values; a RUN cycle advances only if it actually fed
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    samp_d  = samp_q;
    iter_d  = iter_q;
    term_d  = term_q;
    drain_d = drain_q;
    mode_d  = mode_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i && ready_q) begin
          mode_d  = req_mode_i;
          len_d   = req_len_i;
          iter_d  = (req_mode_i == 2'b00 || req_iter_i == '0) ? ITER_BW'(1) : req_iter_i;
          state_d = CFG;
        end
      end
      CFG: begin
        term_d  = '0;
        samp_d  = '0;
        drain_d = '0;
        state_d = (len_q != '0) ? RUN : DONE;
      end
      RUN: begin
        if (xv_q) begin
          if (term_q == iter_q - ITER_BW'(1)) begin
            term_d = '0;
            if (samp_q == len_q - LEN_BW'(1)) begin
              drain_d = '0;
              state_d = DRAIN;
            end else begin
              samp_d = samp_q + LEN_BW'(1);
            end
          end else begin
            term_d = term_q + ITER_BW'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_BW'(DRAIN_CYC - 1)) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + DRAIN_BW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
    clr_d   = (state_d == CFG);
    xv_d    = (state_d == RUN) && !stall;
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  assign req_ready_o = ready_q;
  assign gemm_uno_o  = mode_q;
  assign acc_clr_o   = clr_q;
  assign x_valid_o   = xv_q;
  assign term_idx_o  = term_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: doc/pe_op_scheduler.md
Name: pe_op_scheduler

Overview:
- Sequences one PE through a job: GEMM, or a unary div/exp/log op.
- Drives the PE's 2-bit op-mode select (00 gemm, 01 div, 10 exp, 11 log), which the PE's offset generator and MAC datapath consume.
- Issues per-sample, per-term feed strobes, clears the accumulator at job start, and waits out the PE's registered pipeline before reporting done.
- Sits between the array-level controller (valid/ready job requests) and a single PE.

Parameters:
- LEN_BW, 8: width of the sample-count field.
- ITER_BW, 4: width of the unary term-count field and of the term index.
- DRAIN_CYC, 2: cycles to wait after the last feed for PE outputs (offset register + accumulator) to settle; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid_i  in  1  job request valid
- req_ready_o  out  1  scheduler can accept a job
- req_mode_i  in  2  op mode: 00 gemm, 01 div, 10 exp, 11 log
- req_len_i  in  LEN_BW  number of input samples
- req_iter_i  in  ITER_BW  terms per sample for unary modes; ignored for gemm
- gemm_uno_o  out  2  op-mode select to PE
- acc_clr_o  out  1  accumulator clear to PE
- x_valid_o  out  1  feed strobe: PE consumes x_i this cycle
- term_idx_o  out  ITER_BW  current term index for unary coefficient selection
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle job-complete pulse

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high.
  - Reset values: req_ready_o=1; gemm_uno_o=00; acc_clr_o=0; x_valid_o=0; term_idx_o=0; busy_o=0; done_o=0; state=IDLE; all counters 0.
  - rst asserted in any state aborts the job on the next edge. No done_o is produced for the aborted job.
- All outputs are registered.
- FSM states: IDLE, CFG, RUN, DRAIN, DONE.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i && req_ready_o, latch mode, len and iter, then go to CFG.
  - Effective iter: iter for unary modes, forced to 1 when iter==0; always 1 for gemm.
- CFG (exactly 1 cycle):
  - gemm_uno_o=latched mode; acc_clr_o=1; busy_o=1; req_ready_o=0.
  - Next state: RUN if len>0, else DONE (no feed, no drain).
- RUN:
  - x_valid_o=1 every cycle.
  - term_idx_o counts 0..iter_eff-1. On wrap to 0 the sample counter increments.
  - Leave RUN after the cycle carrying sample len-1 at term iter_eff-1. Total RUN cycles = len*iter_eff.
  - gemm: term_idx_o stays 0.
- DRAIN:
  - x_valid_o=0.
  - Drain counter runs DRAIN_CYC cycles, then goes to DONE.
- DONE (1 cycle):
  - done_o=1, busy_o still 1.
  - Next state IDLE. req_ready_o returns to 1 in the IDLE cycle.
- Mode hold: gemm_uno_o holds its value from CFG through DONE and is retained in IDLE until the next CFG. The PE mode is never changed mid-job.
- Back-to-back jobs: minimum gap between accepts is one IDLE cycle; no accept occurs in DONE.
- Request inputs are sampled only on accept. Changes to them during a job have no effect.
- Arithmetic: the len*iter product is not computed. Nested counters are used, each sized to its field width, with no overflow at maximum values (len=2^LEN_BW-1, iter=2^ITER_BW-1).

Optional Feature:
- Macro: PE_SCHED_STALL_EN.
- When defined:
  - Adds input port stall_i (1 bit).
  - While stall_i=1 in RUN: x_valid_o=0 and term, sample and drain counters freeze. Other states are unaffected.
  - The job resumes exactly where it stopped. Total RUN cycles = len*iter_eff + number of stalled RUN cycles.
- When undefined: no stall_i port, and behaviour is as above.

Test Plan:
- Reset, then an idle cycle:
  - All outputs at reset values.
  - rst=1 mid-RUN returns to IDLE next cycle with x_valid_o=0 and no done_o.
- gemm job, len=5, iter=7, DRAIN_CYC=2:
  - CFG: 1 cycle, acc_clr_o=1.
  - RUN: 5 cycles of x_valid_o, term_idx_o=0 throughout.
  - DRAIN: 2 cycles.
  - done_o pulses at cycle 9 after accept. gemm_uno_o=00 throughout.
- log job, len=3, iter=4:
  - 12 feed cycles with term_idx_o sequence 0,1,2,3 repeated 3 times.
  - gemm_uno_o=11 from CFG onward, and still 11 in IDLE afterwards.
- Edge cases:
  - exp job with iter=0 gives 1 feed per sample.
  - div job with len=0: CFG then DONE, zero x_valid_o cycles, done_o at cycle 2 after accept.
- Back-to-back:
  - req_valid_i held high.
  - Second accept occurs exactly one cycle after done_o.
  - Second job's mode and len are latched correctly.
  - Request inputs changed mid-job are ignored.
- With PE_SCHED_STALL_EN:
  - gemm, len=4; stall_i=1 for 3 cycles after the 2nd feed.
  - Exactly 4 x_valid_o pulses over 7 RUN cycles; done_o delayed by 3 cycles relative to the unstalled case.
